mem_bus_arbiter: RTL and testbench

- Shares one memory port between four requesters (I-fetch, D-access, debug, DMA) using round-robin arbitration.
- Drives the 2-bit select of the mux4 instances that steer address and write data onto the shared port.
- Sequences the single-beat valid/ready transaction with the memory.
- Reports completion or timeout back to the winning requester.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_rr_pick4.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 119 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the four-port memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick4.sv
// Round-robin winner search over four requesters, starting after last_ptr.
module rr_pick4
    import mem_bus_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest set bit is assigned last.
    always_comb begin
        winner = '0;
        idx    = '0;
        any    = |req;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last_ptr + SEL_W'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-beat valid/ready memory port among four requesters.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_we,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] sel,
    output logic             mem_valid,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  err
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  grant_d, done_d, err_d;
    logic [SEL_W-1:0] sel_d;
    logic             mem_valid_d, mem_we_d;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             timeout_hit;

    rr_pick4 u_pick (
        .req      (req),
        .last_ptr (last_ptr_q),
        .winner   (winner),
        .any      (any_req)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State, arbitration pointer, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_ptr_q <= SEL_W'(NREQ - 1);
            cnt_q      <= '0;
            grant      <= '0;
            sel        <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            done       <= '0;
            err        <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
            grant      <= grant_d;
            sel        <= sel_d;
            mem_valid  <= mem_valid_d;
            mem_we     <= mem_we_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req) state_d = ST_BUSY;
            ST_BUSY: if (mem_ready || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; mem_ready takes priority over timeout.
    always_comb begin
        grant_d     = '0;
        sel_d       = '0;
        mem_valid_d = 1'b0;
        mem_we_d    = 1'b0;
        done_d      = '0;
        err_d       = '0;
        cnt_d       = cnt_q;
        last_ptr_d  = last_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d     = onehot(winner);
                    sel_d       = winner;
                    mem_we_d    = req_we[winner];
                    mem_valid_d = 1'b1;
                    last_ptr_d  = winner;
                    cnt_d       = '0;
                end
            end
            ST_BUSY: begin
                sel_d = sel;
                if (mem_ready) begin
                    done_d = onehot(sel);
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : CNT_W'(cnt_q + 1'b1);
                    if (timeout_hit) begin
                        err_d = onehot(sel);
                    end else begin
                        grant_d     = grant;
                        mem_we_d    = mem_we;
                        mem_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: sel_d = sel;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected responses queued at request time, checked on done/err.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic [3:0] done;
        logic [3:0] err;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req_we;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_valid, mem_we, mem_ready;
    logic [3:0] done, err;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    resp_t exp_q[$];

    mem_bus_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .grant     (grant),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Structural invariants checked every cycle once out of the initial reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_tests++;
            if ($countones(grant) > 1 || (done != 0 && err != 0)) begin
                n_fail++;
                $display("FAIL invariant: grant=%b done=%b err=%b", grant, done, err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a done/err pulse; optionally raises mem_ready on the ready_at-th BUSY cycle.
    task automatic wait_resp(input int ready_at, output resp_t r, output int busy_cnt,
                             output logic [3:0] first_grant, output bit stable, output bit ok);
        busy_cnt    = 0;
        ok          = 1'b0;
        stable      = 1'b1;
        first_grant = '0;
        for (int i = 0; i < 100; i++) begin
            if ((done | err) != 0) begin
                ok = 1'b1;
                break;
            end
            if (mem_valid) begin
                busy_cnt++;
                if (busy_cnt == 1) first_grant = grant;
                else if (grant !== first_grant) stable = 1'b0;
                if (ready_at != 0) mem_ready = (busy_cnt >= ready_at);
            end
            step();
        end
        r = '{done: done, err: err};
    endtask

    task automatic check_resp(input string name, input resp_t got, input bit ok);
        resp_t e;
        n_tests++;
        if (!ok || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no response or none expected (ok=%0d queued=%0d)", name, ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: done/err got %b/%b expected %b/%b", name, got.done, got.err, e.done, e.err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; req_we = 4'b1111; mem_ready = 1'b1;
        step(); step();
        n_tests++;
        if ({grant, sel, mem_valid, mem_we, done, err} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {grant, sel, mem_valid, mem_we, done, err});
        end
        rst = 1'b0; req = 4'b0000;
        step(); step();
        n_tests++;
        if ({grant, sel, mem_valid, mem_we, done, err} !== 16'h0) begin
            n_fail++;
            $display("FAIL idle_ready_ignored: got %h expected 0", {grant, sel, mem_valid, mem_we, done, err});
        end
    endtask

    task automatic test_single();
        req = 4'b0010; req_we = 4'b0010; mem_ready = 1'b1;
        exp_q.push_back('{done: 4'b0010, err: 4'b0000});
        step();
        n_tests++;
        if ({grant, sel, mem_valid, mem_we} !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b sel=%0d valid=%b we=%b expected 0010/1/1/1",
                     grant, sel, mem_valid, mem_we);
        end
        step();
        check_resp("single_done", '{done: done, err: err}, (done | err) != 0);
        n_tests++;
        if ({grant, mem_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_done_cycle: grant=%b valid=%b expected 0000/0", grant, mem_valid);
        end
        req = 4'b0000;
        step();
        n_tests++;
        if ({grant, mem_valid, done, err} !== 13'b0) begin
            n_fail++;
            $display("FAIL single_idle: grant=%b valid=%b done=%b err=%b expected all 0", grant, mem_valid, done, err);
        end
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g[$];
        logic [3:0] g;
        int         last_done;
        bit         ok;
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; req_we = 4'b0101; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            exp_g.push_back(g);
            exp_q.push_back('{done: g, err: 4'b0000});
        end
        last_done = 0;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (grant != 0) begin ok = 1'b1; break; end
                step();
            end
            g = exp_g.pop_front();
            n_tests++;
            if (!ok || grant !== g || mem_we !== ((k % 2) == 0)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: grant=%b we=%b expected %b/%b", k, grant, mem_we, g, (k % 2) == 0);
            end
            step();
            check_resp("rr_done", '{done: done, err: err}, (done | err) != 0);
            if (k > 0) begin
                n_tests++;
                if (cyc - last_done != 3) begin
                    n_fail++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, cyc - last_done);
                end
            end
            last_done = cyc;
            req = req & ~done;
            step();
            req = 4'b1111;
        end
        req = 4'b0000; mem_ready = 1'b0;
        step(); step();
    endtask

    task automatic test_wait_states();
        resp_t r; int busy; logic [3:0] fg; bit st, ok;
        req = 4'b0001; req_we = 4'b0000; mem_ready = 1'b0;
        exp_q.push_back('{done: 4'b0001, err: 4'b0000});
        wait_resp(6, r, busy, fg, st, ok);
        check_resp("wait_done", r, ok);
        n_tests++;
        if (busy != 6 || fg !== 4'b0001 || !st) begin
            n_fail++;
            $display("FAIL wait_busy: cycles=%0d grant=%b stable=%0d expected 6/0001/1", busy, fg, st);
        end
        req = 4'b0000; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        resp_t r; int busy; logic [3:0] fg; bit st, ok;
        req = 4'b0100; req_we = 4'b0100; mem_ready = 1'b0;
        exp_q.push_back('{done: 4'b0000, err: 4'b0100});
        wait_resp(0, r, busy, fg, st, ok);
        check_resp("timeout_err", r, ok);
        n_tests++;
        if (busy != 16 || fg !== 4'b0100 || !st) begin
            n_fail++;
            $display("FAIL timeout_busy: cycles=%0d grant=%b stable=%0d expected 16/0100/1", busy, fg, st);
        end
        req = 4'b0000;
        step();
        n_tests++;
        if ({grant, mem_valid, done, err} !== 13'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: grant=%b valid=%b done=%b err=%b expected all 0", grant, mem_valid, done, err);
        end
        req = 4'b0100;
        exp_q.push_back('{done: 4'b0100, err: 4'b0000});
        wait_resp(16, r, busy, fg, st, ok);
        check_resp("timeout_ready_wins", r, ok);
        n_tests++;
        if (busy != 16) begin
            n_fail++;
            $display("FAIL ready_wins_busy: cycles=%0d expected 16", busy);
        end
        req = 4'b0000; mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        resp_t r; int busy; logic [3:0] fg; bit st, ok;
        req = 4'b1000; req_we = 4'b1000; mem_ready = 1'b0;
        step();
        n_tests++;
        if (grant !== 4'b1000 || mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_grant: grant=%b valid=%b expected 1000/1", grant, mem_valid);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if ({grant, sel, mem_valid, mem_we, done, err} !== 16'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h expected 0", {grant, sel, mem_valid, mem_we, done, err});
        end
        rst = 1'b0; req = 4'b1001; req_we = 4'b0000;
        step();
        n_tests++;
        if (grant !== 4'b0001 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_winner: grant=%b sel=%0d expected 0001/0", grant, sel);
        end
        exp_q.push_back('{done: 4'b0001, err: 4'b0000});
        mem_ready = 1'b1;
        wait_resp(0, r, busy, fg, st, ok);
        check_resp("midrst_done", r, ok);
        req = 4'b0000; mem_ready = 1'b0;
        step(); step();
    endtask

    task automatic test_retract();
        resp_t r; int busy; logic [3:0] fg; bit st, ok;
        req = 4'b0100; req_we = 4'b0100; mem_ready = 1'b0;
        step();
        req = 4'b0000; req_we = 4'b0000;
        step(); step();
        n_tests++;
        if ({grant, mem_valid, mem_we, sel} !== {4'b0100, 1'b1, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL retract_hold: grant=%b valid=%b we=%b sel=%0d expected 0100/1/1/2",
                     grant, mem_valid, mem_we, sel);
        end
        exp_q.push_back('{done: 4'b0100, err: 4'b0000});
        mem_ready = 1'b1;
        wait_resp(0, r, busy, fg, st, ok);
        check_resp("retract_done", r, ok);
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; req = '0; req_we = '0; mem_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_retract();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000");
        $fatal(1, "watchdog");
    end

endmodule
